// File: rtl/act_pkg.sv
// Shared definitions for the activation unit.
// Holds the activation mode codes. The controller that drives mode_i
// uses the same codes, so both sides agree on the encoding.
package act_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] ACT_RELU   = 2'd0;
  localparam logic [MODE_W-1:0] ACT_CLIP   = 2'd1;
  localparam logic [MODE_W-1:0] ACT_LEAKY  = 2'd2;
  localparam logic [MODE_W-1:0] ACT_BYPASS = 2'd3;

endpackage

// File: rtl/act_lane.sv
// Single-element activation function, purely combinational.
// Ports:
//   data    in   BITWIDTH  signed element (sign is the MSB)
//   mode    in   2         activation mode (act_pkg codes)
//   result  out  BITWIDTH  activated element
//   zeroed  out  1         element was negative and forced to 0 (RELU/CLIP only)
module act_lane
  import act_pkg::*;
#(
  parameter int unsigned BITWIDTH   = 8,
  parameter int unsigned CLIP_MAX   = 127,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic [BITWIDTH-1:0] data,
  input  logic [MODE_W-1:0]   mode,
  output logic [BITWIDTH-1:0] result,
  output logic                zeroed
);

  localparam logic [BITWIDTH-1:0] CLIP_V = BITWIDTH'(CLIP_MAX);

  logic                       neg_s;
  logic signed [BITWIDTH-1:0] leak_s;

  assign neg_s = data[BITWIDTH-1];

  // Arithmetic shift rounds toward -inf, which is the intended leaky slope.
  always_comb begin
    leak_s = $signed(data) >>> LEAK_SHIFT;
  end

  // Per-mode activation; the clip compare only runs on non-negative values,
  // so an unsigned comparison against the clip bound is exact.
  always_comb begin
    result = data;
    zeroed = 1'b0;
    case (mode)
      ACT_RELU: begin
        if (neg_s) begin
          result = '0;
          zeroed = 1'b1;
        end else begin
          result = data;
        end
      end
      ACT_CLIP: begin
        if (neg_s) begin
          result = '0;
          zeroed = 1'b1;
        end else if (data > CLIP_V) begin
          result = CLIP_V;
        end else begin
          result = data;
        end
      end
      ACT_LEAKY: begin
        if (neg_s) begin
          result = leak_s;
        end else begin
          result = data;
        end
      end
      ACT_BYPASS: begin
        result = data;
      end
      default: begin
        result = data;
      end
    endcase
  end

endmodule

// File: rtl/pipe_act_unit.sv
// Two-stage pipelined multi-lane activation unit with valid/ready on both sides.
// S1 captures the beat and its mode; S2 holds the activated beat and its
// zero count and drives the output. A saturating counter accumulates the
// number of elements zeroed by RELU/CLIP on each output handshake.
// Ports:
//   clk_i        in   1               clock, rising edge
//   rst_n_i      in   1               asynchronous active-low reset
//   mode_i       in   2               activation mode, sampled per accepted beat
//   in_valid_i   in   1               input beat valid
//   in_ready_o   out  1               unit can accept a beat (combinational from out_ready_i)
//   data_i       in   LANES*BITWIDTH  packed signed lanes
//   out_valid_o  out  1               output beat valid
//   out_ready_i  in   1               downstream accepts a beat
//   result_o     out  LANES*BITWIDTH  packed activated lanes
//   cnt_clr_i    in   1               synchronous clear of zero_cnt_o (wins over increment)
//   zero_cnt_o   out  CNT_W           saturating count of zeroed elements
module pipe_act_unit
  import act_pkg::*;
#(
  parameter int unsigned BITWIDTH   = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned CLIP_MAX   = 127,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [MODE_W-1:0]         mode_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*BITWIDTH-1:0] data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANES*BITWIDTH-1:0] result_o,
  input  logic                      cnt_clr_i,
  output logic [CNT_W-1:0]          zero_cnt_o
);

  localparam int unsigned DW   = LANES * BITWIDTH;
  localparam int unsigned ZC_W = $clog2(LANES + 1);

  logic              s1_valid_r;
  logic [DW-1:0]     s1_data_r;
  logic [MODE_W-1:0] s1_mode_r;
  logic              s2_valid_r;
  logic [DW-1:0]     s2_result_r;
  logic [ZC_W-1:0]   s2_zcnt_r;
  logic [CNT_W-1:0]  zero_cnt_r;

  logic              s1_adv_s;
  logic              s2_adv_s;
  logic              out_hs_s;
  logic [DW-1:0]     lane_res_s;
  logic [LANES-1:0]  lane_zero_s;
  logic [ZC_W-1:0]   beat_zc_s;
  logic [CNT_W:0]    cnt_sum_s;

  // A stage may advance when it is empty or the stage after it is draining.
  assign s2_adv_s   = !s2_valid_r || out_ready_i;
  assign s1_adv_s   = !s1_valid_r || s2_adv_s;
  assign out_hs_s   = s2_valid_r && out_ready_i;
  assign in_ready_o = s1_adv_s;

  assign out_valid_o = s2_valid_r;
  assign result_o    = s2_result_r;
  assign zero_cnt_o  = zero_cnt_r;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    act_lane #(
      .BITWIDTH  (BITWIDTH),
      .CLIP_MAX  (CLIP_MAX),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .data  (s1_data_r[k*BITWIDTH +: BITWIDTH]),
      .mode  (s1_mode_r),
      .result(lane_res_s[k*BITWIDTH +: BITWIDTH]),
      .zeroed(lane_zero_s[k])
    );
  end

  // Number of lanes in the S1 beat that the activation forced to zero.
  always_comb begin
    beat_zc_s = '0;
    for (int k = 0; k < LANES; k++) begin
      beat_zc_s = beat_zc_s + ZC_W'(lane_zero_s[k]);
    end
  end

  // One extra bit on the sum exposes overflow for saturation.
  assign cnt_sum_s = {1'b0, zero_cnt_r} + {{(CNT_W + 1 - ZC_W){1'b0}}, s2_zcnt_r};

  // Stage 1: capture input beat and its mode on accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
      s1_mode_r  <= ACT_RELU;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid_i;
      if (in_valid_i) begin
        s1_data_r <= data_i;
        s1_mode_r <= mode_i;
      end
    end
  end

  // Stage 2: register activated beat and its zero count; held while stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid_r  <= 1'b0;
      s2_result_r <= '0;
      s2_zcnt_r   <= '0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_result_r <= lane_res_s;
        s2_zcnt_r   <= beat_zc_s;
      end
    end
  end

  // Saturating zero-element counter; clear has priority over a coincident increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      zero_cnt_r <= '0;
    end else if (cnt_clr_i) begin
      zero_cnt_r <= '0;
    end else if (out_hs_s) begin
      if (cnt_sum_s[CNT_W]) begin
        zero_cnt_r <= '1;
      end else begin
        zero_cnt_r <= cnt_sum_s[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pipe_act_unit.sv
// Randomised and directed bench for pipe_act_unit with a queue-based
// reference model computed from the activation rules in plain integer math.
module tb_pipe_act_unit;

  localparam int BW = 8;
  localparam int LN = 4;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [1:0]    mode_i = 2'd0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [31:0]   data_i = 32'd0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [31:0]   result_o;
  logic          cnt_clr_i = 1'b0;
  logic [CW-1:0] zero_cnt_o;

  pipe_act_unit #(
    .BITWIDTH(BW), .LANES(LN), .CLIP_MAX(100), .LEAK_SHIFT(2), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .mode_i(mode_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .data_i(data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .cnt_clr_i(cnt_clr_i), .zero_cnt_o(zero_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    int          zc;
    int          acc_edge;
  } beat_t;

  beat_t       q[$];
  int          mcnt = 0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_out = 32'd0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: activation by signed integer arithmetic.
  function automatic beat_t model(input logic [1:0] m, input logic [31:0] d);
    beat_t b;
    int x, y;
    b.res = 32'd0;
    b.zc = 0;
    b.acc_edge = 0;
    for (int k = 0; k < LN; k++) begin
      x = int'($signed(d[k*BW +: BW]));
      case (m)
        2'd0: y = (x < 0) ? 0 : x;
        2'd1: y = (x < 0) ? 0 : ((x > 100) ? 100 : x);
        2'd2: y = (x < 0) ? -((-x + 3) / 4) : x;
        default: y = x;
      endcase
      if (x < 0 && (m == 2'd0 || m == 2'd1)) b.zc++;
      b.res[k*BW +: BW] = y[BW-1:0];
    end
    return b;
  endfunction

  // One cycle: check at negedge, advance model, then let the edge happen.
  task automatic step();
    logic exp_ready, exp_valid, acc, ohs;
    beat_t b;
    @(negedge clk_i);
    exp_ready = !(q.size() == 2 && !out_ready_i);
    exp_valid = (q.size() > 0) && (cyc >= q[0].acc_edge + 1);
    check_eq("in_ready", 32'(in_ready_o), 32'(exp_ready));
    check_eq("out_valid", 32'(out_valid_o), 32'(exp_valid));
    if (exp_valid && out_valid_o) check_eq("result", result_o, q[0].res);
    check_eq("zero_cnt", 32'(zero_cnt_o), 32'(mcnt));
    acc = in_valid_i && exp_ready;
    ohs = exp_valid && out_ready_i;
    if (cnt_clr_i) mcnt = 0;
    else if (ohs) mcnt = (mcnt + q[0].zc > CNT_MAX) ? CNT_MAX : mcnt + q[0].zc;
    if (ohs) begin
      last_out = result_o;
      void'(q.pop_front());
    end
    if (acc) begin
      b = model(mode_i, data_i);
      b.acc_edge = cyc + 1;
      q.push_back(b);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_beat(input logic [1:0] m, input logic [31:0] d);
    in_valid_i = 1'b1; mode_i = m; data_i = d; out_ready_i = 1'b1; cnt_clr_i = 1'b0;
    step();
    in_valid_i = 1'b0;
    step();
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_out_valid", 32'(out_valid_o), 32'd0);
    check_eq("rst_result", result_o, 32'd0);
    check_eq("rst_zero_cnt", 32'(zero_cnt_o), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready_o), 32'd1);
    rst_n_i = 1'b1;
    step();

    // Directed vectors
    run_beat(2'd0, 32'h8007_00FB);
    check_eq("relu_vec", last_out, 32'h0007_0000);
    check_eq("relu_cnt", 32'(zero_cnt_o), 32'd2);
    run_beat(2'd1, 32'h32FF_647F);
    check_eq("clip_vec", last_out, 32'h3200_6464);
    run_beat(2'd2, 32'h0980_FFFB);
    check_eq("leaky_vec", last_out, 32'h09E0_FFFE);
    run_beat(2'd3, 32'h0980_FFFB);
    check_eq("bypass_vec", last_out, 32'h0980_FFFB);
    check_eq("cnt_after4", 32'(zero_cnt_o), 32'd3);

    // Back-to-back 8 beats alternating modes
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid_i = 1'b1; mode_i = 2'(i % 4); data_i = $urandom;
      step();
    end
    in_valid_i = 1'b0;
    repeat (3) step();

    // Stall during a stream
    for (int i = 0; i < 10; i++) begin
      in_valid_i = 1'b1; mode_i = 2'($urandom_range(0, 3)); data_i = $urandom;
      out_ready_i = (i >= 2 && i < 7) ? 1'b0 : 1'b1;
      step();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) step();

    // Saturation then clear coincident with handshake
    for (int i = 0; i < 5; i++) run_beat(2'd0, 32'h8080_8080 | ($urandom & 32'h7F7F_7F7F));
    check_eq("cnt_sat", 32'(zero_cnt_o), 32'(CNT_MAX));
    in_valid_i = 1'b1; mode_i = 2'd0; data_i = 32'hFFFF_FFFF;
    step();
    in_valid_i = 1'b0;
    step();
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    check_eq("cnt_clr_hs", 32'(zero_cnt_o), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid_i  = ($urandom_range(0, 9) < 7);
      mode_i      = 2'($urandom_range(0, 3));
      data_i      = $urandom;
      if ($urandom_range(0, 3) == 0) data_i = data_i | 32'h8080_8080;
      out_ready_i = ($urandom_range(0, 9) < 7);
      cnt_clr_i   = ($urandom_range(0, 29) == 0);
      step();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1; cnt_clr_i = 1'b0;
    repeat (3) step();

    // Reset with two beats in flight
    run_beat(2'd0, 32'hFFFF_FFFF);
    in_valid_i = 1'b1; mode_i = 2'd1; data_i = $urandom;
    step();
    data_i = $urandom;
    step();
    in_valid_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid_o), 32'd0);
    check_eq("midrst_zero_cnt", 32'(zero_cnt_o), 32'd0);
    q.delete();
    mcnt = 0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    run_beat(2'd2, 32'h0980_FFFB);
    check_eq("post_rst_vec", last_out, 32'h09E0_FFFE);
    check_eq("post_rst_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
